// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-frame SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

   // {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic int bit_cnt_w(input int total_bits);
      return $clog2(total_bits) + 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCL half-period timebase: half_tick every clk_div+1 cycles, plus leading and
// trailing edge strobes derived from the current SCL level against cpol.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             run,
   input  logic             xfer,
   input  logic             cpol,
   input  logic             scl,
   input  logic [DIV_W-1:0] clk_div,
   output logic             half_tick,
   output logic             lead,
   output logic             trail
);

   logic [DIV_W-1:0] cnt_r;

   // Half-period counter, restarted whenever a new transfer is accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (run) begin
         if (cnt_r == clk_div) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + DIV_W'(1);
         end
      end else begin
         cnt_r <= '0;
      end
   end

   // An edge leaving the idle level is the leading one
   always_comb begin
      half_tick = run && (cnt_r == clk_div);
      lead      = half_tick && xfer && (scl == cpol);
      trail     = half_tick && xfer && (scl != cpol);
   end

endmodule

// File: rtl/spi_master_mf.sv
// Multi-frame SPI master: 1..MAX_FRAMES frames of FRAME_W bits, any CPOL/CPHA.
// Optional SPI_MST_LSB_FIRST_EN adds lsb_first for per-frame LSB-first order.
module spi_master_mf
   import spi_pkg::*;
#(
   parameter  int FRAME_W    = 8,
   parameter  int MAX_FRAMES = 16,
   parameter  int NUM_SS     = 2,
   parameter  int DIV_W      = 8,
   localparam int TOT_W      = FRAME_W * MAX_FRAMES,
   localparam int LEN_W      = $clog2(MAX_FRAMES),
   localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [TOT_W-1:0]  tx_buf,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [SS_W-1:0]   ss_sel,
   input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_MST_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic [TOT_W-1:0]  rx_buf,
   output logic              busy,
   output logic              done,
   output logic              scl,
   output logic [NUM_SS-1:0] ss_n,
   output logic              mosi,
   input  logic              miso
);

   localparam int POS_W = $clog2(TOT_W);
   localparam int BI_W  = $clog2(FRAME_W);
   localparam int BC_W  = bit_cnt_w(TOT_W);

   spi_state_t          state_r;
   logic [TOT_W-1:0]    sh_tx_r;
   logic [LEN_W-1:0]    sh_len_r;
   logic                sh_cpol_r;
   logic                sh_cpha_r;
   logic [DIV_W-1:0]    sh_div_r;
   logic                sh_lsb_r;
   logic [BC_W-1:0]     bit_cnt_r;
   logic [LEN_W-1:0]    fr_r;
   logic [BI_W-1:0]     bi_r;
   logic [TOT_W-1:0]    rx_buf_r;
   logic                busy_r;
   logic                done_r;
   logic                scl_r;
   logic [NUM_SS-1:0]   ss_n_r;
   logic                mosi_r;

   logic                lsb_in_s;
   logic                accept_s;
   logic                run_s;
   logic                xfer_s;
   logic                half_tick_s;
   logic                lead_s;
   logic                trail_s;
   logic                first_bit_s;
   logic [NUM_SS-1:0]   ss_dec_s;
   logic [LEN_W-1:0]    nxt_fr_s;
   logic [BI_W-1:0]     nxt_bi_s;
   logic [POS_W-1:0]    pos_cur_s;
   logic [POS_W-1:0]    pos_nxt_s;
   logic [BC_W-1:0]     last_s;

`ifdef SPI_MST_LSB_FIRST_EN
   assign lsb_in_s = lsb_first;
`else
   assign lsb_in_s = 1'b0;
`endif

   // Flat buffer position of bit bi of frame fr; frame 0 occupies the top bits
   function automatic logic [POS_W-1:0] bit_pos(input logic [LEN_W-1:0] fr,
                                                input logic [BI_W-1:0]  bi,
                                                input logic             lsb);
      int p;
      if (lsb) begin
         p = TOT_W - FRAME_W - int'(fr) * FRAME_W + int'(bi);
      end else begin
         p = TOT_W - 1 - int'(fr) * FRAME_W - int'(bi);
      end
      return POS_W'(p);
   endfunction

   // Bit position bookkeeping and select decode
   always_comb begin
      accept_s    = (state_r == IDLE) && start;
      run_s       = (state_r == SETUP) || (state_r == XFER) || (state_r == HOLD);
      xfer_s      = (state_r == XFER);
      first_bit_s = lsb_in_s ? tx_buf[TOT_W-FRAME_W] : tx_buf[TOT_W-1];
      last_s      = BC_W'((int'(sh_len_r) + 1) * FRAME_W - 1);
      if (bi_r == BI_W'(FRAME_W - 1)) begin
         nxt_bi_s = '0;
         nxt_fr_s = fr_r + LEN_W'(1);
      end else begin
         nxt_bi_s = bi_r + BI_W'(1);
         nxt_fr_s = fr_r;
      end
      pos_cur_s = bit_pos(fr_r, bi_r, sh_lsb_r);
      pos_nxt_s = bit_pos(nxt_fr_s, nxt_bi_s, sh_lsb_r);
      ss_dec_s  = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (ss_sel == SS_W'(i)) begin
            ss_dec_s[i] = 1'b0;
         end else begin
            ss_dec_s[i] = 1'b1;
         end
      end
   end

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (accept_s),
      .run       (run_s),
      .xfer      (xfer_s),
      .cpol      (sh_cpol_r),
      .scl       (scl_r),
      .clk_div   (sh_div_r),
      .half_tick (half_tick_s),
      .lead      (lead_s),
      .trail     (trail_s)
   );

   // Transfer sequencer with registered pin and status outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= IDLE;
         sh_tx_r   <= '0;
         sh_len_r  <= '0;
         sh_cpol_r <= 1'b0;
         sh_cpha_r <= 1'b0;
         sh_div_r  <= '0;
         sh_lsb_r  <= 1'b0;
         bit_cnt_r <= '0;
         fr_r      <= '0;
         bi_r      <= '0;
         rx_buf_r  <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         scl_r     <= 1'b0;
         ss_n_r    <= '1;
         mosi_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               scl_r  <= cpol;
               busy_r <= 1'b0;
               if (start) begin
                  sh_tx_r   <= tx_buf;
                  sh_len_r  <= len;
                  sh_cpol_r <= cpol;
                  sh_cpha_r <= cpha;
                  sh_div_r  <= clk_div;
                  sh_lsb_r  <= lsb_in_s;
                  bit_cnt_r <= '0;
                  fr_r      <= '0;
                  bi_r      <= '0;
                  ss_n_r    <= ss_dec_s;
                  mosi_r    <= cpha ? 1'b0 : first_bit_s;
                  busy_r    <= 1'b1;
                  state_r   <= SETUP;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               scl_r <= sh_cpol_r;
               if (half_tick_s) begin
                  state_r <= XFER;
               end else begin
                  state_r <= SETUP;
               end
            end
            XFER: begin
               if (half_tick_s) begin
                  scl_r <= ~scl_r;
               end else begin
                  scl_r <= scl_r;
               end
               if (lead_s) begin
                  if (sh_cpha_r) begin
                     mosi_r <= sh_tx_r[pos_cur_s];
                  end else begin
                     rx_buf_r[pos_cur_s] <= miso;
                  end
               end else if (trail_s) begin
                  if (sh_cpha_r) begin
                     rx_buf_r[pos_cur_s] <= miso;
                  end
                  if (bit_cnt_r == last_s) begin
                     state_r <= HOLD;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BC_W'(1);
                     fr_r      <= nxt_fr_s;
                     bi_r      <= nxt_bi_s;
                     if (!sh_cpha_r) begin
                        mosi_r <= sh_tx_r[pos_nxt_s];
                     end
                  end
               end
            end
            HOLD: begin
               scl_r <= sh_cpol_r;
               if (half_tick_s) begin
                  ss_n_r  <= '1;
                  state_r <= DONE;
               end else begin
                  state_r <= HOLD;
               end
            end
            DONE: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               mosi_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               ss_n_r  <= '1;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign rx_buf = rx_buf_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign scl    = scl_r;
   assign ss_n   = ss_n_r;
   assign mosi   = mosi_r;

endmodule

// File: tb/tb_spi_master_mf.sv
// Directed bench for spi_master_mf with a mode-aware SPI slave model.
module tb_spi_master_mf;
   import spi_pkg::*;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic         cpol = 1'b0;
   logic         cpha = 1'b0;
   logic [127:0] tx_buf = '0;
   logic [3:0]   len = '0;
   logic [1:0]   ss_sel = '0;
   logic [7:0]   clk_div = '0;
   logic         miso;
   logic [127:0] rx_buf;
   logic         busy, done, scl, mosi;
   logic [2:0]   ss_n;
`ifdef SPI_MST_LSB_FIRST_EN
   logic         lsb_first = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic         m_cpol = 1'b0;
   logic         m_cpha = 1'b0;
   logic [127:0] s_tx = '0;
   logic [127:0] s_cap = '0;
   int           k = 0;
   int           edges = 0;
   int           slv_arm = 0;
   int           arm_seen = 0;

   spi_master_mf #(.FRAME_W(8), .MAX_FRAMES(16), .NUM_SS(3), .DIV_W(8)) dut (
      .clk(clk), .rstn(rstn), .tx_buf(tx_buf), .start(start), .len(len),
      .cpol(cpol), .cpha(cpha), .ss_sel(ss_sel), .clk_div(clk_div),
`ifdef SPI_MST_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .rx_buf(rx_buf), .busy(busy), .done(done), .scl(scl), .ss_n(ss_n),
      .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   assign miso = (k >= 0 && k < 128) ? s_tx[127-k] : 1'b0;

   // Slave: shifts out s_tx MSB first and captures mosi on its sampling edge
   always @(scl, slv_arm) begin
      if (slv_arm != arm_seen) begin
         arm_seen = slv_arm;
         k        = m_cpha ? -1 : 0;
         s_cap    = '0;
      end else begin
         edges++;
         if (scl !== m_cpol) begin
            if (m_cpha) k++;
            else s_cap = {s_cap[126:0], mosi};
         end else begin
            if (m_cpha) s_cap = {s_cap[126:0], mosi};
            else k++;
         end
      end
   end

   task automatic do_xfer(input logic [127:0] t_tx, input logic [3:0] t_len,
                          input logic t_cpol, input logic t_cpha,
                          input logic [1:0] t_ss, input logic [7:0] t_div,
                          input logic [127:0] t_stx, input bit disturb,
                          output int bc, output int dc, output logic [2:0] ss_mid,
                          output int tog, output logic idle_pre,
                          output logic idle_post, output bit tmo);
      int e0;
      @(negedge clk);
      tx_buf = t_tx; len = t_len; cpol = t_cpol; cpha = t_cpha;
      ss_sel = t_ss; clk_div = t_div;
      repeat (2) @(negedge clk);
      idle_pre = scl;
      m_cpol = t_cpol; m_cpha = t_cpha; s_tx = t_stx;
      slv_arm++;
      #1;
      e0 = edges;
      bc = 0; dc = 0; tog = 0; tmo = 1'b1; ss_mid = '0;
      start = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (cyc == 0 && !disturb) start = 1'b0;
         if (disturb && cyc == 3) begin
            tx_buf = ~t_tx;
            cpol = ~t_cpol;
         end
         if (disturb && cyc == 40) start = 1'b0;
         if (busy) bc++;
         if (cyc == 5) ss_mid = ss_n;
         if (done) begin
            dc++;
            tog = edges - e0;
            tmo = 1'b0;
            cpol = t_cpol;
            break;
         end
      end
      start = 1'b0;
      @(negedge clk);
      if (done) dc++;
      idle_post = scl;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (scl !== 1'b0) begin errors++; $display("FAIL rst_scl got %b want 0", scl); end
      checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL rst_ss_n got %b want 111", ss_n); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", mosi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (rx_buf !== 128'h0) begin errors++; $display("FAIL rst_rx got %h want 0", rx_buf); end
      rstn = 1'b1;
   endtask

   task automatic test_full(input string nm, input logic [127:0] t_tx, input logic [127:0] t_stx);
      int bc, dc, tog; logic [2:0] sm; logic ip, iq; bit tmo;
      do_xfer(t_tx, 4'd15, 1'b0, 1'b0, 2'd0, 8'd0, t_stx, 1'b0, bc, dc, sm, tog, ip, iq, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL %s_timeout got no done want done", nm); end
      checks++; if (bc != 259) begin errors++; $display("FAIL %s_busy got %0d want 259", nm, bc); end
      checks++; if (dc != 1) begin errors++; $display("FAIL %s_done_len got %0d want 1", nm, dc); end
      checks++; if (sm !== 3'b110) begin errors++; $display("FAIL %s_ss_n got %b want 110", nm, sm); end
      checks++; if (rx_buf !== t_stx) begin errors++; $display("FAIL %s_rx got %h want %h", nm, rx_buf, t_stx); end
      checks++; if (s_cap !== t_tx) begin errors++; $display("FAIL %s_mosi got %h want %h", nm, s_cap, t_tx); end
      checks++; if (tog != 256) begin errors++; $display("FAIL %s_edges got %0d want 256", nm, tog); end
   endtask

   task automatic test_modes();
      logic [1:0] modes [4] = '{SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};
      int bc, dc, tog; logic [2:0] sm; logic ip, iq; bit tmo;
      for (int m = 0; m < 4; m++) begin
         do_xfer({8'hA5, 120'h0}, 4'd0, modes[m][1], modes[m][0], 2'd1, 8'd1,
                 {8'hA5, 120'h0}, 1'b0, bc, dc, sm, tog, ip, iq, tmo);
         checks++; if (tmo) begin errors++; $display("FAIL mode%0d_timeout got no done want done", m); end
         checks++; if (rx_buf[127:120] !== 8'hA5) begin errors++; $display("FAIL mode%0d_rx got %h want a5", m, rx_buf[127:120]); end
         checks++; if (s_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL mode%0d_mosi got %h want a5", m, s_cap[7:0]); end
         checks++; if (ip !== modes[m][1]) begin errors++; $display("FAIL mode%0d_idle_pre got %b want %b", m, ip, modes[m][1]); end
         checks++; if (iq !== modes[m][1]) begin errors++; $display("FAIL mode%0d_idle_post got %b want %b", m, iq, modes[m][1]); end
         checks++; if (bc != 37) begin errors++; $display("FAIL mode%0d_busy got %0d want 37", m, bc); end
         checks++; if (sm !== 3'b101) begin errors++; $display("FAIL mode%0d_ss_n got %b want 101", m, sm); end
      end
   endtask

   task automatic test_partial();
      int bc, dc, tog; logic [2:0] sm; logic ip, iq; bit tmo;
      do_xfer({40'hF0E1D2C3B4, 88'h0}, 4'd4, 1'b0, 1'b0, 2'd2, 8'd3,
              {{5{8'h3C}}, 88'h0}, 1'b0, bc, dc, sm, tog, ip, iq, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL part_timeout got no done want done"); end
      checks++; if (rx_buf !== 128'h3C3C3C3C3C_ADBEEFDEADBEEFDEADBEEF) begin
         errors++; $display("FAIL part_rx got %h want 3c3c3c3c3cadbeefdeadbeefdeadbeef", rx_buf); end
      checks++; if (s_cap[39:0] !== 40'hF0E1D2C3B4) begin errors++; $display("FAIL part_mosi got %h want f0e1d2c3b4", s_cap[39:0]); end
      checks++; if (bc != 329) begin errors++; $display("FAIL part_busy got %0d want 329", bc); end
      checks++; if (sm !== 3'b011) begin errors++; $display("FAIL part_ss_n got %b want 011", sm); end
   endtask

   task automatic test_back_to_back();
      int bc, dc, tog, extra; logic [2:0] sm; logic ip, iq; bit tmo;
      do_xfer({16'hC3A5, 112'h0}, 4'd1, 1'b0, 1'b1, 2'd0, 8'd1,
              {16'h5AC3, 112'h0}, 1'b1, bc, dc, sm, tog, ip, iq, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout got no done want done"); end
      checks++; if (bc != 69) begin errors++; $display("FAIL b2b_busy got %0d want 69", bc); end
      checks++; if (dc != 1) begin errors++; $display("FAIL b2b_done_len got %0d want 1", dc); end
      checks++; if (tog != 32) begin errors++; $display("FAIL b2b_edges got %0d want 32", tog); end
      checks++; if (rx_buf[127:112] !== 16'h5AC3) begin errors++; $display("FAIL b2b_rx got %h want 5ac3", rx_buf[127:112]); end
      checks++; if (s_cap[15:0] !== 16'hC3A5) begin errors++; $display("FAIL b2b_mosi got %h want c3a5", s_cap[15:0]); end
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL b2b_second got %0d busy cycles want 0", extra); end
   endtask

   task automatic test_reset_mid();
      bit found;
      @(negedge clk);
      tx_buf = {16{8'h96}}; len = 4'd15; cpol = 1'b1; cpha = 1'b0; ss_sel = 2'd1; clk_div = 8'd2;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (scl === 1'b1 && busy === 1'b1) begin found = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_pre got no busy/scl-high want busy with scl=1"); end
      #1 rstn = 1'b0;
      #1;
      checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL rmid_ss_n got %b want 111", ss_n); end
      checks++; if (scl !== 1'b0) begin errors++; $display("FAIL rmid_scl got %b want 0", scl); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rmid_mosi got %b want 0", mosi); end
      checks++; if (rx_buf !== 128'h0) begin errors++; $display("FAIL rmid_rx got %h want 0", rx_buf); end
      cpol = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      test_full("rmid_full", 128'hA5A5A5A5_5A5A5A5A_00FF00FF_C0FFEE11,
                128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
   endtask

   task automatic test_ss_oor();
      int bc, dc, tog; logic [2:0] sm; logic ip, iq; bit tmo;
      do_xfer({16'h1248, 112'h0}, 4'd1, 1'b0, 1'b0, 2'd3, 8'd0,
              {16'h9966, 112'h0}, 1'b0, bc, dc, sm, tog, ip, iq, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL oor_timeout got no done want done"); end
      checks++; if (sm !== 3'b111) begin errors++; $display("FAIL oor_ss_n got %b want 111", sm); end
      checks++; if (dc != 1) begin errors++; $display("FAIL oor_done_len got %0d want 1", dc); end
      checks++; if (tog != 32) begin errors++; $display("FAIL oor_edges got %0d want 32", tog); end
      checks++; if (bc != 35) begin errors++; $display("FAIL oor_busy got %0d want 35", bc); end
      checks++; if (rx_buf[127:112] !== 16'h9966) begin errors++; $display("FAIL oor_rx got %h want 9966", rx_buf[127:112]); end
      checks++; if (s_cap[15:0] !== 16'h1248) begin errors++; $display("FAIL oor_mosi got %h want 1248", s_cap[15:0]); end
   endtask

   initial begin
      test_reset();
      test_full("full", 128'h0123456789ABCDEF_FEDCBA9876543210, {4{32'hDEADBEEF}});
      test_modes();
      test_partial();
      test_back_to_back();
      test_reset_mid();
      test_ss_oor();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
